// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
//   Shared types and constants for the push-button conditioning blocks.
//   - btn_state_e : debounce FSM state encoding
//   - PRESS_CNT_W : width of the wrapping accepted-press counter
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned PRESS_CNT_W = 8;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for quasi-static or slow asynchronous
//   inputs. Both stages reset to RESET_VAL so the synchronized output holds
//   the "inactive" value until real samples have propagated.
//
// Ports
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Conditions one active-low mechanical push-button into a clean debounced
//   level plus single-cycle press / release / long-press strobes and a
//   wrapping count of accepted presses.
//
// Parameters
//   DEBOUNCE_COUNT : stable cycles needed to accept a press or release (>= 1)
//   LONG_COUNT     : cycles held in PRESSED before long_pulse (> DEBOUNCE_COUNT)
//
// Ports
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   btn_n         : raw button, asynchronous, low = pressed
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe per accepted press
//   release_pulse : one-cycle strobe per accepted release
//   long_pulse    : one-cycle strobe, at most once per press
//   press_cnt     : wrapping count of accepted presses
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = 1000000,
    parameter int unsigned LONG_COUNT     = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_n,
    output logic                   btn_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   long_pulse,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_COUNT);
    localparam int unsigned LW = cnt_width(LONG_COUNT);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_COUNT - 1);

    // ------------------------------------------------------------------
    // Synchronizer: reset to released so nothing is seen during reset.
    // ------------------------------------------------------------------
    logic btn_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (btn_s)
    );

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    btn_state_e             state_q,     state_d;
    logic [DW-1:0]          dcnt_q,      dcnt_d;
    logic [LW-1:0]          lcnt_q,      lcnt_d;
    logic                   long_done_q, long_done_d;
    logic                   level_q,     level_d;
    logic                   press_q,     press_d;
    logic                   release_q,   release_d;
    logic                   long_q,      long_d;
    logic [PRESS_CNT_W-1:0] cnt_q,       cnt_d;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                dcnt_d = '0;
                if (!btn_s) begin
                    state_d = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (btn_s) begin
                    // Bounce: drop back and start the stability count over.
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            PRESSED: begin
                if (btn_s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (lcnt_q == LCNT_LAST) begin
                    // lcnt parks at its last value; long_done keeps the
                    // strobe to one per press even though the compare stays
                    // true for the rest of the hold.
                    if (!long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end

            RELEASE_WAIT: begin
                // lcnt is left untouched here so a release bounce resumes
                // the long-press timing where it stopped.
                if (!btn_s) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            cnt_q       <= cnt_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign press_cnt     = cnt_q;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//   Directed and randomized stimulus for btn_debounce with DEBOUNCE_COUNT=4,
//   LONG_COUNT=20. Expected outputs come from a behavioural model: the raw
//   input reaches the debouncer two edges after it is sampled, the accepted
//   level flips once the input has disagreed with it for DEBOUNCE_COUNT+1
//   consecutive sampled edges, and the long strobe fires on the LONG_COUNT-th
//   edge of steady holding after an accepted press.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int DC = 4;
    localparam int LC = 20;

    logic       clk;
    logic       rst_n;
    logic       btn_n;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_cnt;

    btn_debounce #(
        .DEBOUNCE_COUNT (DC),
        .LONG_COUNT     (LC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_cnt     (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors   = 0;
    int miscmp    = 0;

    // Reference model state
    logic m_hist1, m_hist2;   // raw samples from one and two edges ago
    logic m_lvl;
    int   m_run;              // consecutive sampled edges disagreeing with m_lvl
    int   m_held;             // steady-held edges since the last accepted press
    logic m_press, m_rel, m_long;
    int   m_cnt;
    int   m_long_seen;

    task automatic m_reset();
        m_hist1 = 1'b1;
        m_hist2 = 1'b1;
        m_lvl   = 1'b0;
        m_run   = 0;
        m_held  = 0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic m_edge(input logic b);
        logic seen;
        logic disagree;
        seen    = m_hist2;
        m_hist2 = m_hist1;
        m_hist1 = b;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;

        // Steady hold: pressed, no pending release, input still low.
        if (m_lvl && m_run == 0 && !seen) begin
            if (m_held < LC + 1) m_held++;
            if (m_held == LC) m_long = 1'b1;
        end

        disagree = m_lvl ? seen : !seen;
        if (disagree) begin
            m_run++;
            if (m_run == DC + 1) begin
                m_run = 0;
                m_lvl = !m_lvl;
                if (m_lvl) begin
                    m_press = 1'b1;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_held  = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [11:0] got, exp;
        got = {btn_level, press_pulse, release_pulse, long_pulse, press_cnt};
        exp = {m_lvl, m_press, m_rel, m_long, 8'(m_cnt)};
        vectors++;
        assert (got === exp) else begin
            miscmp++;
            $error("FAIL %s t=%0t got{lvl,prs,rel,lng,cnt}=%03h exp=%03h",
                   tag, $time, got, exp);
        end
        if (long_pulse) m_long_seen++;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns after rising.
    task automatic step(input logic b, input string tag);
        btn_n = b;
        @(posedge clk);
        m_edge(b);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    task automatic hold(input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    initial begin
        int n;
        logic lv;
        btn_n       = 1'b1;
        rst_n       = 1'b0;
        m_long_seen = 0;
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press, then release
        hold(1'b1, 3, "idle");
        hold(1'b0, 12, "clean_press");
        assert (press_cnt === 8'd1 && btn_level === 1'b1) else begin
            miscmp++;
            $error("FAIL clean_cnt got cnt=%0d lvl=%b exp cnt=1 lvl=1", press_cnt, btn_level);
        end
        vectors++;
        hold(1'b1, 10, "clean_release");

        // Bounce rejection
        for (int r = 0; r < 5; r++) begin
            hold(1'b0, 3, "bounce_lo");
            hold(1'b1, 2, "bounce_hi");
        end
        hold(1'b1, 6, "bounce_settle");

        // Long press: 6 edges to accept, 40 held, then release
        m_long_seen = 0;
        hold(1'b0, 6 + 40, "long_hold");
        hold(1'b1, 10, "long_release");
        assert (m_long_seen == 1) else begin
            miscmp++;
            $error("FAIL long_once got=%0d long pulses exp=1", m_long_seen);
        end
        vectors++;

        // Release bounce during PRESSED
        hold(1'b0, 10, "rb_press");
        hold(1'b1, 2, "rb_bounce");
        hold(1'b0, 30, "rb_hold");
        hold(1'b1, 10, "rb_release");

        // Wrap-around: 256 more clean presses
        for (int p = 0; p < 256; p++) begin
            hold(1'b0, 8, "wrap_lo");
            hold(1'b1, 8, "wrap_hi");
        end

        // Reset in PRESS_WAIT with the button held
        hold(1'b0, 4, "mid_press");
        rst_n = 1'b0;
        m_reset();
        #1;
        check("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 10, "post_reset_press");
        hold(1'b1, 10, "post_reset_release");

        // Randomized bouncing runs
        lv = 1'b1;
        for (int r = 0; r < 300; r++) begin
            lv = !lv;
            n  = int'($urandom_range(1, 9));
            if ($urandom_range(0, 9) == 0) n = int'($urandom_range(20, 35));
            hold(lv, n, "random");
        end
        hold(1'b1, 10, "final_release");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_btn_debounce

// File: doc/btn_debounce.md
# btn_debounce

Debounces and conditions one active-low mechanical push-button into clean, single-clock events for the board-level LED blinker directly downstream of it. The blinker uses `press_pulse` to step its blink rate and `long_pulse` to toggle enable. The block contains a two-flop synchronizer, a four-state debounce FSM, a long-press timer and a wrapping press counter, all in the system clock domain.

## Interface
- `DEBOUNCE_COUNT`, default 1000000 (20 ms at 50 MHz): number of stable cycles required to accept a press or a release. Legal range ≥ 1. Simulation builds override it to 4.
- `LONG_COUNT`, default 50000000 (1 s): number of cycles held in PRESSED before `long_pulse` fires. Must be greater than `DEBOUNCE_COUNT`. Simulation builds override it to 20.
- `clk` input, 1 bit: system clock. The block has one clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `btn_n` input, 1 bit: raw button, asynchronous to `clk`, low = pressed.
- `btn_level` output, 1 bit: debounced level, 1 = pressed.
- `press_pulse` output, 1 bit: one-cycle strobe on each accepted press.
- `release_pulse` output, 1 bit: one-cycle strobe on each accepted release.
- `long_pulse` output, 1 bit: one-cycle strobe, at most once per press.
- `press_cnt` output, 8 bits: count of accepted presses, wrapping.

## Operation
- **Synchronizer.** `btn_n` passes through two flops to give `btn_s`. Both flops reset to 1 (released).
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- **IDLE:**
  - `btn_s` = 0 → PRESS_WAIT, `dcnt` ← 0.
- **PRESS_WAIT:**
  - `btn_s` = 1 → IDLE and `dcnt` is cleared (bounce rejected).
  - Else, if `dcnt` = `DEBOUNCE_COUNT`-1 → PRESSED; `press_pulse` ← 1; `btn_level` ← 1; `press_cnt` ← `press_cnt`+1; `lcnt` ← 0.
  - Else `dcnt` ← `dcnt`+1.
- **PRESSED:**
  - `btn_s` = 1 → RELEASE_WAIT, `dcnt` ← 0.
  - Else `lcnt` increments.
  - When `lcnt` = `LONG_COUNT`-1, `long_pulse` ← 1 for one cycle. `lcnt` then saturates, so there is no second `long_pulse` for the same press.
- **RELEASE_WAIT:**
  - `btn_s` = 0 → PRESSED. No pulse is generated, `press_cnt` is unchanged, and `lcnt` resumes from its held value.
  - Else, if `dcnt` = `DEBOUNCE_COUNT`-1 → IDLE; `release_pulse` ← 1; `btn_level` ← 0.
  - Else `dcnt` increments. `lcnt` holds throughout RELEASE_WAIT.
- **Widths.**
  - `dcnt` is `$clog2(DEBOUNCE_COUNT)` bits, minimum 1.
  - `lcnt` is `$clog2(LONG_COUNT)` bits.
  - `press_cnt` wraps 255 → 0 with no flag.
- All outputs are registered. The three pulses are high for exactly one cycle and are never high at the same time as each other. `long_pulse` can only be issued in PRESSED, so it cannot coincide with `press_pulse` or `release_pulse`.

## Timing
- **Reset values:** `btn_level`, `press_pulse`, `release_pulse`, `long_pulse` = 0; `press_cnt` = 0; sync flops = 1; counters = 0; state = IDLE.
- **Press latency.** Let edge k be the first edge that samples `btn_n` low, with `btn_n` held low afterwards:
  - PRESS_WAIT is entered at edge k+2.
  - `press_pulse` and `btn_level` rise at edge k+2+`DEBOUNCE_COUNT`.
- **Release latency:** same structure, k+2+`DEBOUNCE_COUNT`.
- **Long-press latency:** `long_pulse` rises `LONG_COUNT` edges after `press_pulse` rises, provided the button is held (RELEASE_WAIT dwell excluded).
- **Bounce.** Any bounce shorter than `DEBOUNCE_COUNT` cycles (measured after synchronization) generates no pulse.
- **Reset mid-operation.** Everything returns to reset values immediately (asynchronous). A button still held low after reset deassertion is accepted as a fresh press at k+2+`DEBOUNCE_COUNT`, counted from the first post-reset edge.

## Structure
- **Package `btn_pkg`:** state enum `btn_state_e` (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the constant `PRESS_CNT_W` = 8.
- **Sub-module `sync_2ff`:** generic two-flop synchronizer with parameter `RESET_VAL`, instantiated with `RESET_VAL` = 1. It is reused by later blocks.
- Next-state and counter logic are combinational. State, counters and outputs are held in flops with asynchronous reset.

## Test plan
All scenarios use `DEBOUNCE_COUNT` = 4 and `LONG_COUNT` = 20.
- **Clean press.** `btn_n` falls and is sampled low at edge k, then held → `press_pulse` high only in the cycle after edge k+6; `btn_level` = 1 from k+6; `press_cnt` = 1.
- **Bounce rejection.** `btn_n` low for 3 cycles, high for 2, repeated 5 times → no pulses, `btn_level` stays 0, `press_cnt` stays 0.
- **Long press.** Hold for 40 cycles after `press_pulse` → exactly one `long_pulse`, 20 edges after `press_pulse`. Then release → `release_pulse` 6 edges after `btn_n` returns high; `btn_level` = 0.
- **Release bounce.** During PRESSED, `btn_n` goes high for 2 cycles then low again → stays in PRESSED, no `release_pulse`, `press_cnt` unchanged.
- **Wrap-around.** 256 clean presses → `press_cnt` goes 255 → 0 on the 256th `press_pulse`.
- **Reset mid-operation.** Assert `rst_n` low while in PRESS_WAIT with the button held → all outputs 0 asynchronously. After deassertion, `press_pulse` occurs 6 edges after the first edge that samples the button low.
